// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared encodings and widths for the two-master SRAM arbiter
package sram_arb_pkg;

    localparam int SRAM_AW      = 18;
    localparam int SRAM_DW      = 16;
    localparam int WORD_AW      = 17;
    localparam int DEFAULT_WAIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_ACK  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sram_rr2.sv
// rtl/sram_rr2.sv - two-way round-robin picker; ptr names the requester granted last
module sram_rr2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - arbitrates two 32-bit masters onto a 16-bit async SRAM as two half accesses
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT = DEFAULT_WAIT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_m0_req,
    input  logic               i_m0_we,
    input  logic [WORD_AW-1:0] i_m0_addr,
    input  logic [31:0]        i_m0_wdata,
    input  logic [3:0]         i_m0_wstrb,
    output logic               o_m0_ack,
    output logic [31:0]        o_m0_rdata,
    input  logic               i_m1_req,
    input  logic               i_m1_we,
    input  logic [WORD_AW-1:0] i_m1_addr,
    input  logic [31:0]        i_m1_wdata,
    input  logic [3:0]         i_m1_wstrb,
    output logic               o_m1_ack,
    output logic [31:0]        o_m1_rdata,
    output logic [SRAM_AW-1:0] o_sram_a,
    inout  wire  [SRAM_DW-1:0] io_sram_d,
    output logic               o_sram_oen,
    output logic               o_sram_wen,
    output logic               o_sram_lbn,
    output logic               o_sram_ubn
);

    localparam int CW = $clog2(WAIT + 1);

    arb_state_t           state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic                 last;
    logic [1:0]           req, gnt;
    logic                 ptr;
    logic                 sel_q;
    logic                 we_q;
    logic [WORD_AW-1:0]   addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic [SRAM_DW-1:0]   lo_buf;
    logic [31:0]          rd0, rd1;
    logic                 drive;
    logic [SRAM_DW-1:0]   dout;
    logic [1:0]           half_strb;
    logic                 grant_now;

    assign req       = {i_m1_req, i_m0_req};
    assign last      = (cnt == CW'(WAIT));
    assign grant_now = (state == ST_IDLE) && (|req);

    sram_rr2 u_rr2 (
        .req (req),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            ST_IDLE: if (|req) state_next = ST_LO;
            ST_LO:   if (last) state_next = ST_HI; else cnt_next = cnt + 1'b1;
            ST_HI:   if (last) state_next = ST_ACK; else cnt_next = cnt + 1'b1;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Pointer reset to m1 so m0 wins the first tie; a reset also drops any latched request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr     <= 1'b1;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (grant_now) begin
            ptr     <= gnt[1];
            sel_q   <= gnt[1];
            we_q    <= gnt[1] ? i_m1_we    : i_m0_we;
            addr_q  <= gnt[1] ? i_m1_addr  : i_m0_addr;
            wdata_q <= gnt[1] ? i_m1_wdata : i_m0_wdata;
            wstrb_q <= gnt[1] ? i_m1_wstrb : i_m0_wstrb;
        end
    end

    // The low half is staged so a requester's rdata changes only once, on the final sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lo_buf <= '0;
            rd0    <= '0;
            rd1    <= '0;
        end else if (!we_q && last) begin
            if (state == ST_LO) begin
                lo_buf <= io_sram_d;
            end else if (state == ST_HI) begin
                if (sel_q) rd1 <= {io_sram_d, lo_buf};
                else       rd0 <= {io_sram_d, lo_buf};
            end
        end
    end

    always_comb begin
        o_sram_a   = '0;
        o_sram_oen = 1'b1;
        o_sram_wen = 1'b1;
        o_sram_lbn = 1'b1;
        o_sram_ubn = 1'b1;
        drive      = 1'b0;
        dout       = '0;
        half_strb  = 2'b00;
        if (state == ST_LO || state == ST_HI) begin
            o_sram_a  = {addr_q, state == ST_HI};
            half_strb = (state == ST_HI) ? wstrb_q[3:2] : wstrb_q[1:0];
            dout      = (state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
            if (we_q) begin
                drive      = 1'b1;
                // Release wen on the final cycle so the address never moves under an active write.
                o_sram_wen = !((|half_strb) && !last);
                o_sram_lbn = ~half_strb[0];
                o_sram_ubn = ~half_strb[1];
            end else begin
                o_sram_oen = 1'b0;
                o_sram_lbn = 1'b0;
                o_sram_ubn = 1'b0;
            end
        end
    end

    assign io_sram_d  = drive ? dout : 'z;
    assign o_m0_ack   = (state == ST_ACK) && !sel_q;
    assign o_m1_ack   = (state == ST_ACK) && sel_q;
    assign o_m0_rdata = rd0;
    assign o_m1_rdata = rd1;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench for sram_arbiter with a small async SRAM read model
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [16:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [17:0] sram_a;
    wire  [15:0] sram_d;
    logic        sram_oen, sram_wen, sram_lbn, sram_ubn;

    int total = 0;
    int bad   = 0;

    logic [17:0] tr_a   [1:4];
    logic        tr_oen [1:4];
    logic        tr_wen [1:4];
    logic        tr_lbn [1:4];
    logic        tr_ubn [1:4];
    logic [15:0] tr_d   [1:4];
    int          lat;
    logic        ack_who;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        case (a)
            18'd0:   return 16'h4241;
            18'd1:   return 16'h4443;
            18'd2:   return 16'hdead;
            default: return 16'hbeaf;
        endcase
    endfunction

    assign sram_d = !sram_oen ? mem_rd(sram_a) : 16'hzzzz;

    sram_arbiter #(.WAIT(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_wstrb(m0_wstrb),
        .o_m0_ack(m0_ack), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
        .o_m1_ack(m1_ack), .o_m1_rdata(m1_rdata),
        .o_sram_a(sram_a), .io_sram_d(sram_d),
        .o_sram_oen(sram_oen), .o_sram_wen(sram_wen),
        .o_sram_lbn(sram_lbn), .o_sram_ubn(sram_ubn)
    );

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one transaction from an idle arbiter and records the first four SRAM cycles.
    task automatic run_txn(input int m, input bit we, input logic [16:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws, input bit pulse);
        @(negedge clk);
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_wstrb = ws;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_wstrb = ws;
        end
        lat = -1;
        ack_who = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                tr_a[k] = sram_a; tr_oen[k] = sram_oen; tr_wen[k] = sram_wen;
                tr_lbn[k] = sram_lbn; tr_ubn[k] = sram_ubn; tr_d[k] = sram_d;
            end
            if (pulse) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            if (m0_ack || m1_ack) begin
                lat = k;
                ack_who = m1_ack;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b exp=00", m1_ack, m0_ack); end
        total++; if (m0_rdata !== 32'h0) begin bad++; $display("FAIL reset_m0_rdata got=%h exp=0", m0_rdata); end
        total++; if (m1_rdata !== 32'h0) begin bad++; $display("FAIL reset_m1_rdata got=%h exp=0", m1_rdata); end
        total++; if (sram_a !== 18'h0) begin bad++; $display("FAIL reset_sram_a got=%h exp=0", sram_a); end
        total++; if ({sram_oen, sram_wen, sram_lbn, sram_ubn} !== 4'b1111) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=1111", {sram_oen, sram_wen, sram_lbn, sram_ubn});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        run_txn(0, 1'b0, 17'd0, 32'h0, 4'h0, 1'b0);
        total++; if (lat !== 5) begin bad++; $display("FAIL rd0_latency got=%0d exp=5", lat); end
        total++; if (ack_who !== 1'b0) begin bad++; $display("FAIL rd0_ack_who got=%0d exp=0", ack_who); end
        for (int k = 1; k <= 4; k++) begin
            total++; if (tr_a[k] !== ((k <= 2) ? 18'd0 : 18'd1)) begin bad++; $display("FAIL rd0_a[%0d] got=%0d exp=%0d", k, tr_a[k], (k <= 2) ? 0 : 1); end
            total++; if ({tr_oen[k], tr_wen[k], tr_lbn[k], tr_ubn[k]} !== 4'b0100) begin
                bad++; $display("FAIL rd0_ctrl[%0d] got=%b exp=0100", k, {tr_oen[k], tr_wen[k], tr_lbn[k], tr_ubn[k]});
            end
        end
        total++; if (m0_rdata !== 32'h44434241) begin bad++; $display("FAIL rd0_rdata got=%h exp=44434241", m0_rdata); end
    endtask

    task automatic test_m1_read();
        run_txn(1, 1'b0, 17'd1, 32'h0, 4'h0, 1'b0);
        total++; if (lat !== 5) begin bad++; $display("FAIL rd1_latency got=%0d exp=5", lat); end
        total++; if (ack_who !== 1'b1) begin bad++; $display("FAIL rd1_ack_who got=%0d exp=1", ack_who); end
        total++; if (tr_a[1] !== 18'd2 || tr_a[4] !== 18'd3) begin bad++; $display("FAIL rd1_addr got=%0d,%0d exp=2,3", tr_a[1], tr_a[4]); end
        total++; if (m1_rdata !== 32'hbeafdead) begin bad++; $display("FAIL rd1_rdata got=%h exp=beafdead", m1_rdata); end
        total++; if (m0_rdata !== 32'h44434241) begin bad++; $display("FAIL rd1_m0_held got=%h exp=44434241", m0_rdata); end
    endtask

    task automatic test_write();
        logic [3:0] exp_wen = 4'b1101;
        run_txn(0, 1'b1, 17'd5, 32'h11223344, 4'b0100, 1'b0);
        total++; if (lat !== 5) begin bad++; $display("FAIL wr_latency got=%0d exp=5", lat); end
        for (int k = 1; k <= 4; k++) begin
            total++; if (tr_oen[k] !== 1'b1) begin bad++; $display("FAIL wr_oen[%0d] got=%b exp=1", k, tr_oen[k]); end
            total++; if (tr_wen[k] !== exp_wen[4-k]) begin bad++; $display("FAIL wr_wen[%0d] got=%b exp=%b", k, tr_wen[k], exp_wen[4-k]); end
            total++; if (tr_a[k] !== ((k <= 2) ? 18'd10 : 18'd11)) begin bad++; $display("FAIL wr_a[%0d] got=%0d exp=%0d", k, tr_a[k], (k <= 2) ? 10 : 11); end
        end
        total++; if (tr_d[3] !== 16'h1122 || tr_d[4] !== 16'h1122) begin bad++; $display("FAIL wr_hi_bus got=%h,%h exp=1122", tr_d[3], tr_d[4]); end
        total++; if (tr_d[1] !== 16'h3344) begin bad++; $display("FAIL wr_lo_bus got=%h exp=3344", tr_d[1]); end
        total++; if ({tr_lbn[3], tr_ubn[3]} !== 2'b01) begin bad++; $display("FAIL wr_hi_be got=%b exp=01", {tr_lbn[3], tr_ubn[3]}); end
        total++; if ({tr_lbn[1], tr_ubn[1]} !== 2'b11) begin bad++; $display("FAIL wr_lo_be got=%b exp=11", {tr_lbn[1], tr_ubn[1]}); end
        total++; if (m0_rdata !== 32'h44434241) begin bad++; $display("FAIL wr_rdata_held got=%h exp=44434241", m0_rdata); end
    endtask

    task automatic test_zero_strobe_pulse();
        run_txn(1, 1'b1, 17'd7, 32'haaaa5555, 4'b0000, 1'b1);
        total++; if (lat !== 5) begin bad++; $display("FAIL zs_latency got=%0d exp=5", lat); end
        total++; if (ack_who !== 1'b1) begin bad++; $display("FAIL zs_ack_who got=%0d exp=1", ack_who); end
        for (int k = 1; k <= 4; k++) begin
            total++; if ({tr_oen[k], tr_wen[k], tr_lbn[k], tr_ubn[k]} !== 4'b1111) begin
                bad++; $display("FAIL zs_ctrl[%0d] got=%b exp=1111", k, {tr_oen[k], tr_wen[k], tr_lbn[k], tr_ubn[k]});
            end
        end
        total++; if (m1_rdata !== 32'hbeafdead) begin bad++; $display("FAIL zs_rdata_held got=%h exp=beafdead", m1_rdata); end
    endtask

    task automatic test_alternate();
        int  n = 0;
        int  dbl = 0;
        int  gap = 0;
        logic seq [0:5];
        pulse_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 17'd1;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) dbl++;
            if (m0_ack || m1_ack) begin
                seq[n] = m1_ack;
                n++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        total++; if (n !== 6) begin bad++; $display("FAIL alt_count got=%0d exp=6", n); end
        total++; if (dbl !== 0) begin bad++; $display("FAIL alt_double_ack got=%0d exp=0", dbl); end
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                total++; if (seq[i] !== i[0]) begin bad++; $display("FAIL alt_grant[%0d] got=%0d exp=%0d", i, seq[i], i[0]); end
            end
        end
        total++; if (m0_rdata !== 32'h44434241) begin bad++; $display("FAIL alt_m0_rdata got=%h exp=44434241", m0_rdata); end
        total++; if (m1_rdata !== 32'hbeafdead) begin bad++; $display("FAIL alt_m1_rdata got=%h exp=beafdead", m1_rdata); end
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) gap++;
        end
        total++; if (gap !== 0) begin bad++; $display("FAIL alt_no_repeat got=%0d exp=0", gap); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'd2;
        @(posedge clk);
        repeat (3) @(negedge clk);
        total++; if (sram_a !== 18'd5) begin bad++; $display("FAIL rm_hi_addr got=%0d exp=5", sram_a); end
        rst = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL rm_ack got=%b%b exp=00", m1_ack, m0_ack); end
        total++; if ({sram_oen, sram_wen, sram_lbn, sram_ubn} !== 4'b1111) begin
            bad++; $display("FAIL rm_ctrl got=%b exp=1111", {sram_oen, sram_wen, sram_lbn, sram_ubn});
        end
        total++; if (sram_a !== 18'd0) begin bad++; $display("FAIL rm_addr got=%0d exp=0", sram_a); end
        total++; if (m0_rdata !== 32'h0) begin bad++; $display("FAIL rm_rdata got=%h exp=0", m0_rdata); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack || !sram_oen) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL rm_stray got=%0d exp=0", stray); end
        run_txn(1, 1'b0, 17'd0, 32'h0, 4'h0, 1'b0);
        total++; if (lat !== 5) begin bad++; $display("FAIL rm_next_latency got=%0d exp=5", lat); end
        total++; if (m1_rdata !== 32'h44434241) begin bad++; $display("FAIL rm_next_rdata got=%h exp=44434241", m1_rdata); end
        total++; if (m0_rdata !== 32'h0) begin bad++; $display("FAIL rm_m0_untouched got=%h exp=0", m0_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_m1_read();
        test_write();
        test_zero_strobe_pulse();
        test_alternate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT, default 1, minimum 1: SRAM cycles per 16-bit half-access beyond the first.
REQ-002 i_clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_m0_req / i_m1_req  in  1  requester N wants a 32-bit word transaction.
REQ-005 i_mN_we  in  1  1 = write, 0 = read.
REQ-006 i_mN_addr  in  17  word address.
REQ-007 i_mN_wdata  in  32  write data.
REQ-008 i_mN_wstrb  in  4  byte enables; bit k covers wdata[8k+7:8k].
REQ-009 o_mN_ack  out  1  one-cycle completion pulse.
REQ-010 o_mN_rdata  out  32  read data, valid with ack.
REQ-011 o_sram_a  out  18  SRAM halfword address.
REQ-012 io_sram_d  inout  16  SRAM data bus.
REQ-013 o_sram_oen / o_sram_wen  out  1  output / write enable, active-low.
REQ-014 o_sram_lbn / o_sram_ubn  out  1  lower / upper byte enable, active-low.

Function
REQ-015 FSM states: IDLE, LO, HI, ACK.
- IDLE: any request -> LO.
- LO: after WAIT+1 cycles -> HI.
- HI: after WAIT+1 cycles -> ACK.
- ACK: -> IDLE after one cycle.
REQ-016 IDLE with any req high at edge N: grant one requester and latch its we/addr/wdata/wstrb at edge N.
- LO occupies cycles N+1..N+1+WAIT; HI follows.
- Granted ack is high exactly during cycle N+2*(WAIT+1)+1 (WAIT=1: N+5).
REQ-017 Arbitration: two-way round-robin on a last-granted pointer.
- Both requesting: grant the one not last granted.
- Single requester: grant it regardless of the pointer.
- Pointer updates on grant.
REQ-018 LO drives o_sram_a = {addr,0} and maps to data bits [15:0] / strobes [1:0].
REQ-019 HI drives o_sram_a = {addr,1} and maps to data bits [31:16] / strobes [3:2].
REQ-020 Address is held constant for every cycle of a phase.
REQ-021 Read phase:
- oen low, wen high, lbn = ubn = 0.
- Bus undriven.
- io_sram_d sampled into the matching rdata half on the last cycle of the phase.
REQ-022 Write phase:
- oen high.
- Bus driven with the matching wdata half.
- wen low in all phase cycles except the last, which is high, so address never changes while wen is low.
- lbn/ubn = inverted strobes for that half.
REQ-023 Write phase with both strobes of that half zero: the phase still consumes WAIT+1 cycles, with wen high throughout.
REQ-024 Outside a write phase, io_sram_d is high-Z.
REQ-025 In IDLE and ACK: oen = wen = lbn = ubn = 1.
REQ-026 o_mN_rdata is updated only by reads for requester N; it is held between transactions; writes leave it unchanged.
REQ-027 The latched transaction always completes even if req drops before ack; the ungranted requester's req is held pending.
REQ-028 At most one ack is high per cycle; no ack is ever issued without a grant.
REQ-029 Back-to-back: a req still high in the IDLE cycle after ACK is treated as a new transaction.
- Requester must drop req in its ack cycle to avoid a repeat.

Reset
REQ-030 Reset values:
- State = IDLE; pointer = m1, so m0 wins the first tie.
- All acks 0; both rdata = 0.
- o_sram_a = 0; oen = wen = lbn = ubn = 1; bus high-Z.
REQ-031 Reset asserted mid-transaction aborts it at the next edge: no ack, SRAM controls deasserted, latched request discarded.

Structure
REQ-032 Shared package sram_arb_pkg holds:
- State encodings.
- Widths: SRAM_AW = 18, SRAM_DW = 16, WORD_AW = 17.
- Default WAIT.
REQ-033 One sub-module, sram_rr2: a two-way round-robin picker (req[1:0], pointer in; one-hot grant out); it contains no SRAM logic.

Verification
REQ-034 Bench SRAM model returns:
- 0x4241 at a = 0, 0x4443 at a = 1.
- 0xdead at a = 2, 0xbeaf otherwise.
- Driven only while oen is low.
REQ-035 Single read, m0 addr 0, WAIT=1 -> o_m0_rdata = 0x44434241; ack 5 cycles after the grant edge; a sequence 0,0,1,1.
REQ-036 m1 read addr 1 -> o_m1_rdata = 0xbeafdead; o_m0_rdata unchanged.
REQ-037 Both requesting continuously from reset -> grants alternate m0, m1, m0, m1; never two acks in one cycle.
REQ-038 m0 write addr 5, wdata 0x11223344, wstrb 0b0100:
- LO phase: wen stays high.
- HI phase: bus 0x1122, wen low for WAIT cycles then high; lbn = 0, ubn = 1.
- oen is high throughout.
REQ-039 Reset pulsed during the HI phase of a read -> no ack, controls idle next cycle, and the next request is granted normally.
